run_sequencer: RTL and testbench

//  Initiator side of the go/done start handshake used by the LED counting FSM.

---
 rtl/run_sequencer.sv | 171 +++++++++++++++++
 tb/tb_run_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// run_sequencer: initiator side of the go/done start handshake.
// Debounces an active-low push button. Each accepted press issues RUNS go requests
// to a worker, with a GAP_CYCLES pause between runs. A run is aborted if the worker
// stalls in REQ or in WAIT for TIMEOUT_CYCLES.

module run_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 300000,
    parameter int unsigned RUNS            = 3,
    parameter int unsigned GAP_CYCLES      = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 30000000
) (
    input  logic       clk30,
    input  logic       rst,
    input  logic       button_n,
    input  logic       busy,
    input  logic       done,
    output logic       go,
    output logic       active,
    output logic [7:0] run_count,
    output logic       timeout_err,
    output logic [1:0] state_dbg
);

    localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned ToW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RemW = $clog2(RUNS + 1);

    localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [ToW-1:0]  ToLast  = ToW'(TIMEOUT_CYCLES - 1);
    localparam logic [RemW-1:0] RemInit = RemW'(RUNS);
    localparam logic [RemW-1:0] RemOne  = RemW'(1);

    typedef enum logic [1:0] {
        st_idle = 2'b00,
        st_req  = 2'b01,
        st_wait = 2'b10,
        st_gap  = 2'b11
    } state_t;

    state_t         state;
    logic           btn_meta, btn_sync, btn_stable;
    logic [DbW-1:0] db_cnt;
    logic           press;
    logic           done_meta, done_sync, done_prev;
    logic           done_rise;
    logic [RemW-1:0] remaining;
    logic [GapW-1:0] gap_cnt;
    logic [ToW-1:0]  timer;

    // Button synchroniser and debouncer; press pulses only on a stable 1->0 transition.
    always_ff @(posedge clk30) begin
        if (rst) begin
            btn_meta   <= 1'b1;
            btn_sync   <= 1'b1;
            btn_stable <= 1'b1;
            db_cnt     <= '0;
            press      <= 1'b0;
        end else begin
            btn_meta <= button_n;
            btn_sync <= btn_meta;
            press    <= 1'b0;
            if (btn_sync == btn_stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DbLast) begin
                btn_stable <= btn_sync;
                db_cnt     <= '0;
                press      <= ~btn_sync;
            end else begin
                db_cnt <= db_cnt + DbW'(1);
            end
        end
    end

    // done synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk30) begin
        if (rst) begin
            done_meta <= 1'b0;
            done_sync <= 1'b0;
            done_prev <= 1'b0;
        end else begin
            done_meta <= done;
            done_sync <= done_meta;
            done_prev <= done_sync;
        end
    end

    assign done_rise = done_sync & ~done_prev;

    // Sequencer FSM; go/active are registered alongside every state change.
    always_ff @(posedge clk30) begin
        if (rst) begin
            state       <= st_idle;
            go          <= 1'b0;
            active      <= 1'b0;
            run_count   <= 8'd0;
            timeout_err <= 1'b0;
            remaining   <= '0;
            gap_cnt     <= '0;
            timer       <= '0;
        end else begin
            case (state)
                st_idle: begin
                    if (press) begin
                        state       <= st_req;
                        go          <= 1'b1;
                        active      <= 1'b1;
                        remaining   <= RemInit;
                        run_count   <= 8'd0;
                        timeout_err <= 1'b0;
                        timer       <= '0;
                    end
                end
                st_req: begin
                    // done_rise is deliberately ignored here; only busy moves us on.
                    if (busy) begin
                        state <= st_wait;
                        go    <= 1'b0;
                        timer <= '0;
                    end else if (timer == ToLast) begin
                        state       <= st_idle;
                        go          <= 1'b0;
                        active      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + ToW'(1);
                    end
                end
                st_wait: begin
                    if (done_rise) begin
                        if (run_count != 8'hFF) begin
                            run_count <= run_count + 8'd1;
                        end
                        remaining <= remaining - RemW'(1);
                        if (remaining == RemOne) begin
                            state  <= st_idle;
                            active <= 1'b0;
                        end else begin
                            state   <= st_gap;
                            gap_cnt <= '0;
                        end
                    end else if (timer == ToLast) begin
                        state       <= st_idle;
                        active      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        timer <= timer + ToW'(1);
                    end
                end
                st_gap: begin
                    if (gap_cnt == GapLast) begin
                        state <= st_req;
                        go    <= 1'b1;
                        timer <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GapW'(1);
                    end
                end
                default: begin
                    state  <= st_idle;
                    go     <= 1'b0;
                    active <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed testbench for run_sequencer with small parameters.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.

module tb_run_sequencer;

    localparam int unsigned DEBOUNCE_CYCLES = 4;
    localparam int unsigned RUNS            = 3;
    localparam int unsigned GAP_CYCLES      = 2;
    localparam int unsigned TIMEOUT_CYCLES  = 16;

    localparam int S_IDLE = 0;
    localparam int S_REQ  = 1;
    localparam int S_WAIT = 2;
    localparam int S_GAP  = 3;

    logic       clk30 = 1'b0;
    logic       rst;
    logic       button_n;
    logic       busy;
    logic       done;
    logic       go;
    logic       active;
    logic [7:0] run_count;
    logic       timeout_err;
    logic [1:0] state_dbg;

    int n_checks  = 0;
    int n_errors  = 0;
    int press_cnt = 0;

    run_sequencer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RUNS            (RUNS),
        .GAP_CYCLES      (GAP_CYCLES),
        .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
    ) dut (
        .clk30       (clk30),
        .rst         (rst),
        .button_n    (button_n),
        .busy        (busy),
        .done        (done),
        .go          (go),
        .active      (active),
        .run_count   (run_count),
        .timeout_err (timeout_err),
        .state_dbg   (state_dbg)
    );

    always #5 clk30 = ~clk30;

    always @(negedge clk30) begin
        if (dut.press) press_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk30);
        #1;
    endtask

    task automatic wait_go();
        int n = 0;
        while (go !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("wait_go", 32'(go), 1);
    endtask

    // Worker model: ack after ack_dly cycles, then done pulse done_dly cycles later.
    task automatic worker(input int ack_dly, input int done_dly);
        wait_go();
        repeat (ack_dly) tick();
        busy = 1'b1;
        repeat (done_dly) tick();
        busy = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic release_and_press();
        button_n = 1'b1;
        repeat (10) tick();
        button_n = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic quiet;

        rst      = 1'b1;
        button_n = 1'b1;
        busy     = 1'b0;
        done     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_go", 32'(go), 0);
        check("rst_active", 32'(active), 0);
        check("rst_run_count", 32'(run_count), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_state", 32'(state_dbg), S_IDLE);

        // 1: bouncy press, exactly one press pulse, go one cycle later
        button_n = 1'b0;
        tick();
        tick();
        button_n = 1'b1;
        tick();
        button_n = 1'b0;
        repeat (5) tick();
        check("bounce_press_early", 32'(dut.press), 0);
        check("bounce_go_early", 32'(go), 0);
        tick();
        check("bounce_press", 32'(dut.press), 1);
        check("bounce_go_pre", 32'(go), 0);
        tick();
        check("bounce_press_end", 32'(dut.press), 0);
        check("bounce_go", 32'(go), 1);

        // 2: nominal three runs
        for (int k = 1; k <= 3; k++) begin
            worker(3, 5);
            repeat (2) tick();
            check("nom_run_count", 32'(run_count), k);
            if (k < 3) begin
                check("nom_state_gap", 32'(state_dbg), S_GAP);
                tick();
                check("nom_gap_go", 32'(go), 0);
                tick();
                check("nom_go_again", 32'(go), 1);
            end else begin
                check("nom_state_idle", 32'(state_dbg), S_IDLE);
                check("nom_active", 32'(active), 0);
                check("nom_timeout_err", 32'(timeout_err), 0);
            end
        end
        button_n = 1'b1;
        repeat (10) tick();
        check("release_go", 32'(go), 0);
        check("release_active", 32'(active), 0);
        check("release_press_cnt", 32'(press_cnt), 1);

        // 3: REQ timeout
        button_n = 1'b0;
        wait_go();
        cnt = 0;
        while (go === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        check("req_to_go_cycles", 32'(cnt), TIMEOUT_CYCLES);
        check("req_to_state", 32'(state_dbg), S_IDLE);
        check("req_to_err", 32'(timeout_err), 1);
        check("req_to_run_count", 32'(run_count), 0);
        release_and_press();
        wait_go();
        check("req_to_err_clear", 32'(timeout_err), 0);

        // 4: WAIT timeout, then done on the last WAIT cycle wins
        repeat (2) tick();
        busy = 1'b1;
        tick();
        cnt = 0;
        while (state_dbg == 2'(S_WAIT) && cnt < 40) begin
            cnt++;
            tick();
        end
        check("wait_to_cycles", 32'(cnt), TIMEOUT_CYCLES);
        check("wait_to_err", 32'(timeout_err), 1);
        check("wait_to_state", 32'(state_dbg), S_IDLE);
        check("wait_to_run_count", 32'(run_count), 0);
        busy = 1'b0;
        release_and_press();
        wait_go();
        button_n = 1'b1;
        repeat (2) tick();
        busy = 1'b1;
        repeat (14) tick();
        busy = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (2) tick();
        check("prio_run_count", 32'(run_count), 1);
        check("prio_err", 32'(timeout_err), 0);
        check("prio_state", 32'(state_dbg), S_GAP);

        // 5: busy and done together in REQ, press in WAIT, done in IDLE
        repeat (2) tick();
        wait_go();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        busy = 1'b1;
        tick();
        check("coinc_state", 32'(state_dbg), S_WAIT);
        check("coinc_run_count", 32'(run_count), 1);
        button_n = 1'b0;
        repeat (8) tick();
        check("wait_press_state", 32'(state_dbg), S_WAIT);
        check("wait_press_go", 32'(go), 0);
        check("wait_press_run_count", 32'(run_count), 1);
        done = 1'b1;
        tick();
        done = 1'b0;
        busy = 1'b0;
        repeat (2) tick();
        check("coinc_counted_later", 32'(run_count), 2);
        check("coinc_gap", 32'(state_dbg), S_GAP);
        worker(1, 2);
        repeat (2) tick();
        check("third_run_count", 32'(run_count), 3);
        check("third_idle", 32'(state_dbg), S_IDLE);
        done = 1'b1;
        tick();
        done = 1'b0;
        repeat (4) tick();
        check("idle_done_run_count", 32'(run_count), 3);
        check("idle_done_state", 32'(state_dbg), S_IDLE);
        check("idle_done_go", 32'(go), 0);

        // 6: reset in the middle of WAIT
        release_and_press();
        worker(2, 3);
        repeat (2) tick();
        check("pre_rst_run_count", 32'(run_count), 1);
        wait_go();
        repeat (2) tick();
        busy = 1'b1;
        repeat (2) tick();
        check("pre_rst_state", 32'(state_dbg), S_WAIT);
        rst = 1'b1;
        tick();
        rst  = 1'b0;
        busy = 1'b0;
        check("mid_rst_go", 32'(go), 0);
        check("mid_rst_active", 32'(active), 0);
        check("mid_rst_run_count", 32'(run_count), 0);
        check("mid_rst_state", 32'(state_dbg), S_IDLE);
        check("mid_rst_err", 32'(timeout_err), 0);
        quiet = 1'b1;
        repeat (2) begin
            tick();
            if (go !== 1'b0 || active !== 1'b0) quiet = 1'b0;
        end
        button_n = 1'b1;
        repeat (10) begin
            tick();
            if (go !== 1'b0 || active !== 1'b0) quiet = 1'b0;
        end
        check("post_rst_quiet", 32'(quiet), 1);
        check("total_press_cnt", 32'(press_cnt), 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
